// File: rtl/led_io_pkg.sv
// Register map and CTRL bit positions shared by the LED output port and its bench.
package led_io_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;
    localparam int CTRL_CLR = 2;

endpackage

// File: rtl/led_blink_timer.sv
// Blink timebase: free-running prescaler feeding an 8-bit period counter that toggles phase.
module led_blink_timer
    import led_io_pkg::*;
#(
    parameter int PRESCALE_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] period,
    input  logic       period_wr,
    input  logic       clr,
    output logic       phase
);

    logic [PRESCALE_W-1:0] presc_p0;
    logic [7:0]            count_p0;
    logic                  phase_p0;
    logic                  tick;

    assign tick  = &presc_p0;
    assign phase = phase_p0;

    // prescaler -> period counter -> phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_p0 <= '0;
            count_p0 <= '0;
            phase_p0 <= 1'b0;
        end else if (clr) begin
            presc_p0 <= '0;
            count_p0 <= '0;
            phase_p0 <= 1'b0;
        end else begin
            presc_p0 <= presc_p0 + 1'b1;
            if (period == 8'd0) begin
                count_p0 <= '0;
                phase_p0 <= 1'b0;
            end else if (period_wr) begin
                // a new period restarts the count so it can never sit above PERIOD-1
                count_p0 <= '0;
            end else if (tick) begin
                if (count_p0 == period - 8'd1) begin
                    count_p0 <= '0;
                    phase_p0 <= ~phase_p0;
                end else begin
                    count_p0 <= count_p0 + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/led_io_port.sv
// Memory-mapped LED port: register file, read mux, blink timer and registered LED drive.
module led_io_port
    import led_io_pkg::*;
#(
    parameter int PRESCALE_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] led
);

    logic [7:0] data_p0;
    logic [7:0] mask_p0;
    logic [7:0] period_p0;
    logic       en_p0;
    logic       inv_p0;
    logic       phase;
    logic       period_wr;
    logic       clr;
    logic [7:0] rd_mux;
    logic [7:0] led_next;
    logic [7:0] led_p1;
    logic [7:0] rdata_p1;

    assign period_wr = wr_en && (addr == ADDR_PERIOD);
    assign clr       = wr_en && (addr == ADDR_CTRL) && wdata[CTRL_CLR];

    // register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p0   <= 8'h00;
            mask_p0   <= 8'h00;
            period_p0 <= 8'h00;
            en_p0     <= 1'b1;
            inv_p0    <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                ADDR_DATA:   data_p0   <= wdata;
                ADDR_MASK:   mask_p0   <= wdata;
                ADDR_PERIOD: period_p0 <= wdata;
                default: begin
                    en_p0  <= wdata[CTRL_EN];
                    inv_p0 <= wdata[CTRL_INV];
                end
            endcase
        end
    end

    led_blink_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .period    (period_p0),
        .period_wr (period_wr),
        .clr       (clr),
        .phase     (phase)
    );

    // read mux sees pre-write contents, so a same-cycle write is not forwarded
    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            ADDR_DATA:   rd_mux = data_p0;
            ADDR_MASK:   rd_mux = mask_p0;
            ADDR_PERIOD: rd_mux = period_p0;
            default:     rd_mux = {3'b000, phase, 2'b00, inv_p0, en_p0};
        endcase
    end

    always_comb begin
        led_next = 8'h00;
        if (en_p0) begin
            led_next = (data_p0 & ~(mask_p0 & {8{phase}})) ^ {8{inv_p0}};
        end
    end

    // output stage: LED drive and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_p1   <= 8'h00;
            rdata_p1 <= 8'h00;
        end else begin
            led_p1 <= led_next;
            if (rd_en) begin
                rdata_p1 <= rd_mux;
            end
        end
    end

    assign led   = led_p1;
    assign rdata = rdata_p1;

endmodule

// File: tb/tb_led_io_port.sv
// Bench for led_io_port: directed scenarios and random traffic against a tick-count phase model.
module tb_led_io_port;
    import led_io_pkg::*;

    localparam int PW = 2;
    localparam int PS = 1 << PW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] led;

    int ncmp = 0;
    int nfail = 0;

    // reference state: phase is derived from ticks counted since the last restart
    logic [7:0] m_data, m_mask, m_period;
    logic       m_en, m_inv, m_base;
    int         m_ticks, m_pcyc;
    logic [7:0] exp_led, exp_rdata;

    led_io_port #(.PRESCALE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .led   (led)
    );

    always #5 clk = ~clk;

    function automatic logic cur_phase();
        if (m_period == 8'd0) return m_base;
        return m_base ^ logic'((m_ticks / int'(m_period)) % 2);
    endfunction

    task automatic model_reset();
        m_data = 8'h00; m_mask = 8'h00; m_period = 8'h00;
        m_en = 1'b1; m_inv = 1'b0; m_base = 1'b0;
        m_ticks = 0; m_pcyc = 0;
        exp_led = 8'h00; exp_rdata = 8'h00;
    endtask

    task automatic model_edge(input logic wr, input logic rd, input logic [1:0] a, input logic [7:0] wd);
        logic p;
        logic tick;
        p = cur_phase();
        exp_led = m_en ? ((m_data & ~(m_mask & {8{p}})) ^ {8{m_inv}}) : 8'h00;
        if (rd) begin
            case (a)
                2'd0: exp_rdata = m_data;
                2'd1: exp_rdata = m_mask;
                2'd2: exp_rdata = m_period;
                default: exp_rdata = {3'b000, p, 2'b00, m_inv, m_en};
            endcase
        end
        if (wr && a == 2'd3 && wd[2]) begin
            m_pcyc = 0; m_ticks = 0; m_base = 1'b0;
        end else begin
            tick = ((m_pcyc % PS) == PS - 1);
            m_pcyc++;
            if (m_period == 8'd0) begin
                m_ticks = 0; m_base = 1'b0;
            end else if (wr && a == 2'd2) begin
                m_base = p; m_ticks = 0;
            end else if (tick) begin
                m_ticks++;
            end
        end
        if (wr) begin
            case (a)
                2'd0: m_data = wd;
                2'd1: m_mask = wd;
                2'd2: m_period = wd;
                default: begin m_en = wd[0]; m_inv = wd[1]; end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic wr, input logic rd, input logic [1:0] a, input logic [7:0] wd);
        wr_en = wr; rd_en = rd; addr = a; wdata = wd;
        @(posedge clk);
        model_edge(wr, rd, a, wd);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        chk("model_led", led, exp_led);
        chk("model_rdata", rdata, exp_rdata);
    endtask

    task automatic w(input logic [1:0] a, input logic [7:0] wd);
        step(1'b1, 1'b0, a, wd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        logic [1:0] ra;
        logic [7:0] rw;
        model_reset();
        #12;
        chk("reset_led", led, 8'h00);
        chk("reset_rdata", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, 1'b1, ADDR_CTRL, 8'h00);
        chk("reset_ctrl_read", rdata, 8'h01);

        // plain output, one cycle latency
        w(ADDR_DATA, 8'hA5);
        idle();
        chk("plain_a5", led, 8'hA5);

        // blink: toggles every PERIOD*4 = 8 clocks after the CLR write
        w(ADDR_DATA, 8'hFF);
        w(ADDR_MASK, 8'h0F);
        w(ADDR_PERIOD, 8'd2);
        w(ADDR_CTRL, 8'h05);
        for (int k = 1; k <= 24; k++) begin
            idle();
            chk("blink", led, (((k - 1) / 8) % 2 == 1) ? 8'hF0 : 8'hFF);
        end

        // period rewrite while phase=1, on a tick edge
        w(ADDR_CTRL, 8'h05);
        for (int k = 1; k <= 11; k++) idle();
        w(ADDR_PERIOD, 8'd3);
        step(1'b0, 1'b1, ADDR_CTRL, 8'h00);
        chk("rewrite_phase_kept", rdata, 8'h11);
        for (int j = 2; j <= 13; j++) begin
            idle();
            if (j == 12) chk("rewrite_before_toggle", led, 8'hF0);
            if (j == 13) chk("rewrite_after_toggle", led, 8'hFF);
        end

        // PERIOD=0 stops blinking with LEDs on
        w(ADDR_PERIOD, 8'd0);
        for (int k = 0; k < 3; k++) idle();
        chk("period_zero", led, 8'hFF);

        // invert and disable
        w(ADDR_MASK, 8'h00);
        w(ADDR_DATA, 8'h3C);
        w(ADDR_CTRL, 8'h03);
        idle();
        chk("invert", led, 8'hC3);
        w(ADDR_CTRL, 8'h00);
        idle();
        chk("disabled", led, 8'h00);
        w(ADDR_DATA, 8'h5A);
        idle();
        chk("disabled_data", led, 8'h00);
        w(ADDR_CTRL, 8'h01);

        // read during write returns old contents
        w(ADDR_DATA, 8'h11);
        step(1'b1, 1'b1, ADDR_DATA, 8'h22);
        chk("rdw_old", rdata, 8'h11);
        step(1'b0, 1'b1, ADDR_DATA, 8'h00);
        chk("rdw_new", rdata, 8'h22);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            ra = 2'($urandom_range(0, 3));
            rw = 8'($urandom);
            if (ra == ADDR_PERIOD) rw = 8'($urandom_range(0, 4));
            if (ra == ADDR_CTRL && $urandom_range(0, 3) != 0) rw[0] = 1'b1;
            if (ra == ADDR_CTRL && $urandom_range(0, 3) != 0) rw[2] = 1'b0;
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), ra, rw);
        end

        // asynchronous reset mid-blink
        w(ADDR_DATA, 8'hFF);
        w(ADDR_MASK, 8'h0F);
        w(ADDR_PERIOD, 8'd1);
        w(ADDR_CTRL, 8'h01);
        for (int k = 0; k < 6; k++) idle();
        step(1'b0, 1'b1, ADDR_DATA, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_led", led, 8'h00);
        chk("async_reset_rdata", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, ADDR_CTRL, 8'h00);
        chk("post_reset_ctrl", rdata, 8'h01);
        chk("post_reset_led", led, 8'h00);
        step(1'b0, 1'b1, ADDR_DATA, 8'h00);
        chk("post_reset_data", rdata, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
